// File: rtl/csa_operand_feeder_if.sv
// Bundle of the operand-feeder signals: the upstream word stream, the
// operand/sum connection to the external 3-input carry-save adder, and the
// downstream result handshake. The feeder uses the slave modport; the
// environment around it (source, adder, sink) uses the master modport.
interface csa_operand_feeder_if #(
  parameter int WIDTH = 64
);
  // Upstream operand words
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  // Registered operands to the adder and its combinational sum
  logic [WIDTH-1:0] csa_a;
  logic [WIDTH-1:0] csa_b;
  logic [WIDTH-1:0] csa_c;
  logic [WIDTH-1:0] csa_s;

  // Downstream result
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_count;

  modport master (
    output in_valid, in_data, in_last, csa_s, out_ready,
    input  in_ready, csa_a, csa_b, csa_c, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, csa_s, out_ready,
    output in_ready, csa_a, csa_b, csa_c, out_valid, out_data, out_count
  );
endinterface

// File: rtl/csa_operand_feeder.sv
// Collects groups of 1-3 operand words, presents them as three registered
// operands to an external carry-save adder, captures the adder's sum one
// cycle after the group's final word, and holds it until downstream takes it.
// Unused operand slots are zero so short groups sum only their real words.
module csa_operand_feeder #(
  parameter int WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  csa_operand_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    COL0 = 3'd0,  // waiting for the first word of a group
    COL1 = 3'd1,  // waiting for the second word
    COL2 = 3'd2,  // waiting for the third (always final) word
    CAP  = 3'd3,  // adder inputs settled; sample the sum
    OUT  = 3'd4   // result presented until accepted
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] csa_a_q;
  logic [WIDTH-1:0] csa_b_q;
  logic [WIDTH-1:0] csa_c_q;
  logic [1:0]       count_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_count_q;

  logic in_fire;
  logic out_fire;

  // Handshakes qualified by the registered ready/valid so stray strobes in
  // CAP/OUT (input side) or outside OUT (output side) are ignored.
  assign in_fire  = bus.in_valid  && in_ready_q;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Controller and datapath registers: operand slots fill in order, the sum
  // is captured in CAP and held in OUT until the output handshake.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COL0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      csa_a_q     <= '0;
      csa_b_q     <= '0;
      csa_c_q     <= '0;
      count_q     <= 2'd0;
      out_data_q  <= '0;
      out_count_q <= 2'd0;
    end else begin
      case (state_q)
        COL0: begin
          if (in_fire) begin
            // A new group starts: clear the upper slots so a short group
            // does not pick up operands left over from the previous one.
            csa_a_q <= bus.in_data;
            csa_b_q <= '0;
            csa_c_q <= '0;
            count_q <= 2'd1;
            if (bus.in_last) begin
              state_q    <= CAP;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= COL1;
            end
          end
        end

        COL1: begin
          if (in_fire) begin
            csa_b_q <= bus.in_data;
            count_q <= 2'd2;
            if (bus.in_last) begin
              state_q    <= CAP;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= COL2;
            end
          end
        end

        COL2: begin
          if (in_fire) begin
            // Third word always closes the group, regardless of in_last.
            csa_c_q    <= bus.in_data;
            count_q    <= 2'd3;
            state_q    <= CAP;
            in_ready_q <= 1'b0;
          end
        end

        CAP: begin
          // Operands have been stable for a full cycle, so the adder output
          // is settled; the sum wraps naturally at WIDTH bits.
          out_data_q  <= bus.csa_s;
          out_count_q <= count_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end

        OUT: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= COL0;
          end
        end

        default: begin
          // Unused encodings recover to an idle, empty state.
          state_q     <= COL0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.csa_a     = csa_a_q;
  assign bus.csa_b     = csa_b_q;
  assign bus.csa_c     = csa_c_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_csa_operand_feeder.sv
// Self-checking bench for csa_operand_feeder: a table of directed groups with
// hand-computed sums, hand-written sequences for latency, wrap, backpressure,
// single-word and reset corner cases, and a randomized stream against a
// queue-based scoreboard. The 3-input adder is modelled here.
module tb_csa_operand_feeder;

  localparam int WIDTH = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;

  csa_operand_feeder_if #(.WIDTH(WIDTH)) bus ();

  csa_operand_feeder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational adder (mod 2^64)
  assign bus.csa_s = bus.csa_a + bus.csa_b + bus.csa_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Wait (bounded) until in_ready is seen high at a falling edge, then present
  // one word for exactly the following rising edge.
  task automatic push_word(input logic [63:0] d, input logic last);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("push_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  // Wait (bounded) for out_valid at a falling edge.
  task automatic wait_out_valid(input string name);
    int waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.out_valid !== 1'b1) check({name, "_timeout"}, 64'(bus.out_valid), 64'd1);
  endtask

  typedef struct {
    int          n;
    logic [63:0] w [3];
    logic [63:0] exp_sum;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs [8];

  logic [63:0] exp_q [$];
  int          n_rand_groups;
  int          n_rx;

  initial begin
    vecs[0] = '{3, '{64'd1, 64'd2, 64'd3}, 64'd6, 2'd3};
    vecs[1] = '{1, '{64'h1234, 64'd0, 64'd0}, 64'h1234, 2'd1};
    vecs[2] = '{2, '{ONES, 64'd2, 64'd0}, 64'd1, 2'd2};
    vecs[3] = '{3, '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1}, 64'd1, 2'd3};
    vecs[4] = '{3, '{ONES, ONES, ONES}, 64'hFFFF_FFFF_FFFF_FFFD, 2'd3};
    vecs[5] = '{2, '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'd0}, ONES, 2'd2};
    vecs[6] = '{1, '{64'd0, 64'd0, 64'd0}, 64'd0, 2'd1};
    vecs[7] = '{3, '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 64'd1},
                64'h1234_5678_9ABC_DF01, 2'd3};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  bus.out_data,       64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_csa_a",     bus.csa_a,          64'd0);
    check("rst_csa_b",     bus.csa_b,          64'd0);
    check("rst_csa_c",     bus.csa_c,          64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // ---------------- full group, exact latency ----------------
    bus.out_ready = 1'b1;
    push_word(64'd1, 1'b0);
    push_word(64'd2, 1'b0);
    push_word(64'd3, 1'b1);
    // one edge after the final word: CAP
    check("lat_cap_out_valid", 64'(bus.out_valid), 64'd0);
    check("lat_cap_in_ready",  64'(bus.in_ready),  64'd0);
    @(negedge clk);
    check("lat_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_out_data",  bus.out_data,       64'd6);
    check("lat_out_count", 64'(bus.out_count), 64'd3);
    @(negedge clk);
    check("lat_valid_one_cycle", 64'(bus.out_valid), 64'd0);
    check("lat_back_in_ready",   64'(bus.in_ready),  64'd1);

    // ---------------- short group with wrap, then backpressure ----------------
    bus.out_ready = 1'b0;
    push_word(ONES, 1'b0);
    push_word(64'd2, 1'b1);
    check("wrap_cap_csa_c", bus.csa_c, 64'd0);
    check("wrap_cap_csa_a", bus.csa_a, ONES);
    check("wrap_cap_csa_b", bus.csa_b, 64'd2);
    @(negedge clk);
    // upstream pushes a stray word while the block is not ready
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0BAD_0BAD_0BAD_0BAD;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data",  bus.out_data,       64'd1);
      check("bp_out_count", 64'(bus.out_count), 64'd2);
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
      @(negedge clk);
    end
    check("bp_csa_a_untouched", bus.csa_a, ONES);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    check("bp_stray_not_taken",   bus.csa_a,          ONES);

    // ---------------- single word, no leakage of previous B ----------------
    push_word(64'h1234, 1'b1);
    check("single_cap_csa_b", bus.csa_b, 64'd0);
    check("single_cap_csa_c", bus.csa_c, 64'd0);
    @(negedge clk);
    check("single_out_data",  bus.out_data,       64'h1234);
    check("single_out_count", 64'(bus.out_count), 64'd1);
    @(negedge clk);

    // ---------------- table of directed groups ----------------
    foreach (vecs[k]) begin
      for (int j = 0; j < vecs[k].n; j++)
        push_word(vecs[k].w[j], (j == vecs[k].n - 1));
      wait_out_valid($sformatf("vec%0d", k));
      check($sformatf("vec%0d_sum", k),   bus.out_data,       vecs[k].exp_sum);
      check($sformatf("vec%0d_count", k), 64'(bus.out_count), 64'(vecs[k].exp_cnt));
      @(negedge clk);
    end

    // ---------------- reset mid-group ----------------
    push_word(64'd100, 1'b0);
    push_word(64'd200, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_csa_a",     bus.csa_a,          64'd0);
    check("midrst_csa_b",     bus.csa_b,          64'd0);
    check("midrst_out_data",  bus.out_data,       64'd0);
    check("midrst_out_count", 64'(bus.out_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      check("midrst_no_result", 64'(seen), 64'd0);
    end
    push_word(64'd7, 1'b0);
    push_word(64'd8, 1'b0);
    push_word(64'd9, 1'b1);
    wait_out_valid("after_rst");
    check("after_rst_sum",   bus.out_data,       64'd24);
    check("after_rst_count", 64'(bus.out_count), 64'd3);
    @(negedge clk);

    // ---------------- reset while a result is pending ----------------
    bus.out_ready = 1'b0;
    push_word(64'd5, 1'b1);
    @(negedge clk);
    check("outrst_pending", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("outrst_valid_dropped", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("outrst_no_result", 64'(bus.out_valid), 64'd0);
    check("outrst_in_ready",  64'(bus.in_ready),  64'd1);

    // ---------------- random stream vs scoreboard ----------------
    n_rand_groups = 40;
    n_rx = 0;
    fork
      begin : producer
        for (int g = 0; g < n_rand_groups; g++) begin
          int          n;
          logic [63:0] w;
          logic [63:0] sum;
          n   = $urandom_range(1, 3);
          sum = '0;
          for (int j = 0; j < n; j++) begin
            w = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) w = ONES - 64'($urandom_range(0, 3));
            sum += w;
            if (j == n - 1) exp_q.push_back(sum);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_word(w, (j == n - 1));
          end
        end
      end
      begin : consumer
        int cycles = 0;
        while (n_rx < n_rand_groups && cycles < 4000) begin
          @(negedge clk);
          cycles++;
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_valid === 1'b1 && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected_result", bus.out_data, 64'd0);
            end else begin
              check($sformatf("rand_sum%0d", n_rx), bus.out_data, exp_q.pop_front());
            end
            n_rx++;
          end
        end
      end
    join
    @(negedge clk);
    check("rand_results_received", 64'(n_rx), 64'(n_rand_groups));
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
